// File: rtl/serial_sub4_if.sv
// serial_sub4_if: handshake/data bundle for the bit-serial subtractor.
//   start, X, Y, borrowin : request and operands (master -> slave)
//   D, borrowout, busy, done : result and status (slave -> master)
//   ovf : signed overflow, present only when SUB_OVF_EN is defined
interface serial_sub4_if #(parameter int WIDTH = 4);
  logic             start;
  logic [WIDTH-1:0] X;
  logic [WIDTH-1:0] Y;
  logic             borrowin;
  logic [WIDTH-1:0] D;
  logic             borrowout;
  logic             busy;
  logic             done;
`ifdef SUB_OVF_EN
  logic             ovf;
`endif

  modport master (
    output start, X, Y, borrowin,
    input  D, borrowout, busy, done
`ifdef SUB_OVF_EN
    , input ovf
`endif
  );

  modport slave (
    input  start, X, Y, borrowin,
    output D, borrowout, busy, done
`ifdef SUB_OVF_EN
    , output ovf
`endif
  );
endinterface

// File: rtl/serial_sub4.sv
// serial_sub4: bit-serial two's-complement subtractor, D = X - Y - borrowin,
// one bit per clock from the LSB over WIDTH cycles, behind a start/done
// handshake.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : serial_sub4_if slave (start, X, Y, borrowin in;
//          D, borrowout, busy, done [, ovf] out)
// Optional feature macro: SUB_OVF_EN adds the registered signed-overflow
// output ovf.
module serial_sub4 #(
  parameter int WIDTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  serial_sub4_if.slave bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] x_sh;
  logic [WIDTH-1:0] y_sh;
  logic [WIDTH-1:0] d_q;
  logic             b_q;
  logic             bo_q;
  logic [CW-1:0]    cnt;

  logic xb, yb, d_bit, b_next;

  always_comb begin
    xb     = x_sh[0];
    yb     = y_sh[0];
    d_bit  = xb ^ yb ^ b_q;
    b_next = (~xb & yb) | (~(xb ^ yb) & b_q);
  end

`ifdef SUB_OVF_EN
  // Operand MSBs are kept aside because the shift registers lose them.
  logic xmsb, ymsb, ovf_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      x_sh  <= '0;
      y_sh  <= '0;
      d_q   <= '0;
      b_q   <= 1'b0;
      bo_q  <= 1'b0;
      cnt   <= '0;
`ifdef SUB_OVF_EN
      xmsb  <= 1'b0;
      ymsb  <= 1'b0;
      ovf_q <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            x_sh  <= bus.X;
            y_sh  <= bus.Y;
            b_q   <= bus.borrowin;
            cnt   <= '0;
            state <= SHIFT;
`ifdef SUB_OVF_EN
            xmsb  <= bus.X[WIDTH-1];
            ymsb  <= bus.Y[WIDTH-1];
`endif
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          x_sh <= x_sh >> 1;
          y_sh <= y_sh >> 1;
          d_q  <= {d_bit, d_q[WIDTH-1:1]};
          b_q  <= b_next;
          bo_q <= b_next;
          cnt  <= cnt + CW'(1);
          if (cnt == LAST) begin
            state <= DONE;
`ifdef SUB_OVF_EN
            // d_bit on the last shift is the final result MSB.
            ovf_q <= (xmsb ^ ymsb) & (xmsb ^ d_bit);
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.D         = d_q;
  assign bus.borrowout = bo_q;
  assign bus.busy      = (state == SHIFT);
  assign bus.done      = (state == DONE);
`ifdef SUB_OVF_EN
  assign bus.ovf       = ovf_q;
`endif

endmodule
